// File: rtl/vga_frame_reader.sv
// Burst-read sequencer: walks a DDR frame buffer with fixed-length Avalon-MM
// burst reads and pushes the returned 128-bit words into the pixel FIFO.
module vga_frame_reader #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          ddr_clk,
  input  logic                          ddr_reset_n,
  input  logic                          enable,
  input  logic [ADDR_W-1:0]             frame_base,
  input  logic [23:0]                   frame_words,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_wr_used,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_read,
  output logic [$clog2(BURST_LEN):0]    avm_burstcount,
  input  logic                          avm_waitrequest,
  input  logic                          avm_readdatavalid,
  input  logic [127:0]                  avm_readdata,
  output logic                          fifo_wr_en,
  output logic [127:0]                  fifo_wr_data,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int unsigned BC_W   = $clog2(BURST_LEN) + 1;
  localparam int unsigned CREDIT = MAX_OUTSTANDING * BURST_LEN;
  localparam int unsigned IF_W   = $clog2(CREDIT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_base_q, cur_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       req_cnt_q, req_cnt_d;
  logic [23:0]       rx_cnt_q, rx_cnt_d;
  logic [IF_W-1:0]   in_flight_q, in_flight_d;
  logic              read_q, read_d;
  logic              wr_en_q, wr_en_d;
  logic [127:0]      wr_data_q, wr_data_d;
  logic              done_q, done_d;

  logic              accept;
  logic              issue;
  logic [24:0]       req_next;
  logic [ADDR_W-1:0] req_addr;

  // Request address is derived from the frame base latched at the last wrap,
  // so a frame_base change only takes effect on the next frame.
  assign req_addr = cur_base_q + ADDR_W'({req_cnt_q, 4'b0000});
  assign req_next = {1'b0, req_cnt_q} + 25'(BURST_LEN);
  assign accept   = read_q && !avm_waitrequest;

  // Credit covers words already requested but not yet written, which also
  // absorbs the one-cycle lag of fifo_wr_used.
  assign issue = (state_q == RUN) && enable && !read_q
              && (32'(fifo_wr_used) + 32'(in_flight_q) + BURST_LEN <= FIFO_DEPTH)
              && (32'(in_flight_q) + BURST_LEN <= CREDIT);

  always_comb begin
    state_d     = state_q;
    cur_base_d  = cur_base_q;
    addr_d      = addr_q;
    req_cnt_d   = req_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    read_d      = read_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    in_flight_d = in_flight_q + (accept ? IF_W'(BURST_LEN) : IF_W'(0)) - IF_W'(wr_en_q);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = RUN;
          cur_base_d = frame_base;
          req_cnt_d  = '0;
          rx_cnt_d   = '0;
        end
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (in_flight_q == '0 && !read_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      read_d = 1'b1;
      addr_d = req_addr;
    end

    if (accept) begin
      read_d = 1'b0;
      if (req_next >= {1'b0, frame_words}) begin
        req_cnt_d  = '0;
        cur_base_d = frame_base;
      end else begin
        req_cnt_d = req_next[23:0];
      end
    end

    if (state_q != IDLE && avm_readdatavalid) begin
      wr_en_d   = 1'b1;
      wr_data_d = avm_readdata;
      if (rx_cnt_q == frame_words - 24'd1) begin
        rx_cnt_d = '0;
        done_d   = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      state_q     <= IDLE;
      cur_base_q  <= '0;
      addr_q      <= '0;
      req_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      in_flight_q <= '0;
      read_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_base_q  <= cur_base_d;
      addr_q      <= addr_d;
      req_cnt_q   <= req_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      in_flight_q <= in_flight_d;
      read_q      <= read_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_burstcount = BC_W'(BURST_LEN);
  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_data   = wr_data_q;
  assign frame_done     = done_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader with an in-order DDR burst responder.
module tb_vga_frame_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [31:0]  frame_base = '0;
  logic [23:0]  frame_words = 24'd76800;
  logic [8:0]   fifo_wr_used = '0;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic [4:0]   avm_burstcount;
  logic         avm_waitrequest = 1'b0;
  logic         avm_readdatavalid = 1'b0;
  logic [127:0] avm_readdata = '0;
  logic         fifo_wr_en;
  logic [127:0] fifo_wr_data;
  logic         frame_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .ADDR_W(32), .BURST_LEN(16), .FIFO_DEPTH(256), .MAX_OUTSTANDING(4)
  ) dut (
    .ddr_clk(clk), .ddr_reset_n(rst_n), .enable(enable),
    .frame_base(frame_base), .frame_words(frame_words), .fifo_wr_used(fifo_wr_used),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  // Responder / monitor state, updated on the falling edge.
  logic         resp_hold = 1'b0;
  logic         inj_valid = 1'b0;
  int           ncyc = 0;
  int           beat = 16;
  logic [31:0]  cur_addr = '0;
  logic [31:0]  acc_addr[$];
  logic [31:0]  pend_addr[$];
  int           pend_rdy[$];
  logic [127:0] wr_q[$];
  int           fd_idx[$];
  int           wr_cnt = 0;
  int           stray_fd = 0;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {4{a}};
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      acc_addr.delete(); pend_addr.delete(); pend_rdy.delete();
      wr_q.delete(); fd_idx.delete();
      beat = 16; wr_cnt = 0; stray_fd = 0; avm_readdatavalid = 1'b0;
    end else begin
      if (fifo_wr_en) begin
        wr_q.push_back(fifo_wr_data);
        wr_cnt++;
        if (frame_done) fd_idx.push_back(wr_cnt);
      end else if (frame_done) begin
        stray_fd++;
      end
      if (avm_read && !avm_waitrequest) begin
        acc_addr.push_back(avm_address);
        pend_addr.push_back(avm_address);
        pend_rdy.push_back(ncyc + 2);
      end
      if (beat == 16 && pend_addr.size() > 0 && pend_rdy[0] <= ncyc) begin
        cur_addr = pend_addr.pop_front();
        void'(pend_rdy.pop_front());
        beat = 0;
      end
      if (inj_valid) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pat(32'hDEAD0000);
      end else if (!resp_hold && beat < 16) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pat(cur_addr + 32'(beat * 16));
        beat++;
      end else begin
        avm_readdatavalid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; resp_hold = 1'b0; inj_valid = 1'b0; avm_waitrequest = 1'b0;
    fifo_wr_used = '0; frame_base = '0; frame_words = 24'd76800;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 600) begin step(1); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout busy=%b exp 0", name, busy); end
  endtask

  task automatic test_reset();
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", avm_read); end
    checks++; if (avm_address !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", avm_address); end
    checks++; if (avm_burstcount !== 5'd16) begin errors++; $display("FAIL rst_burstcount got %0d exp 16", avm_burstcount); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", fifo_wr_en); end
    checks++; if (fifo_wr_data !== 128'h0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", fifo_wr_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
  endtask

  task automatic test_fill();
    int n;
    int bad;
    do_reset();
    resp_hold = 1'b1;
    enable = 1'b1;
    step(1);
    checks++; if (busy !== 1'b1 || avm_read !== 1'b0) begin errors++; $display("FAIL fill_enter_run busy=%b read=%b exp 1/0", busy, avm_read); end
    step(1);
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL fill_first_read got %b exp 1", avm_read); end
    checks++; if (avm_address !== 32'h0) begin errors++; $display("FAIL fill_first_addr got %h exp 0", avm_address); end
    checks++; if (avm_burstcount !== 5'd16) begin errors++; $display("FAIL fill_burstcount got %0d exp 16", avm_burstcount); end
    step(40);
    checks++; if (acc_addr.size() != 4) begin errors++; $display("FAIL fill_burst_count got %0d exp 4", acc_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < acc_addr.size()) begin
        checks++;
        if (acc_addr[i] !== 32'(i * 256)) begin errors++; $display("FAIL fill_addr%0d got %h exp %h", i, acc_addr[i], 32'(i * 256)); end
      end
    end
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL fill_stall_read got %b exp 0", avm_read); end
    resp_hold = 1'b0;
    n = 0;
    while (wr_cnt < 64 && n < 300) begin step(1); n++; end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= wr_q.size() || wr_q[i] !== pat(32'(i * 16))) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_data bad_words=%0d exp 0 (written %0d)", bad, wr_cnt); end
    enable = 1'b0;
    wait_idle("fill");
    checks++; if (wr_cnt != 16 * acc_addr.size()) begin errors++; $display("FAIL fill_drain_words got %0d exp %0d", wr_cnt, 16 * acc_addr.size()); end
  endtask

  task automatic test_credit();
    do_reset();
    fifo_wr_used = 9'd250;
    resp_hold = 1'b1;
    enable = 1'b1;
    step(20);
    checks++; if (acc_addr.size() != 0 || avm_read !== 1'b0) begin errors++; $display("FAIL credit_250 bursts=%0d read=%b exp 0/0", acc_addr.size(), avm_read); end
    fifo_wr_used = 9'd240;
    step(20);
    checks++; if (acc_addr.size() != 1) begin errors++; $display("FAIL credit_240 bursts got %0d exp 1", acc_addr.size()); end
    if (acc_addr.size() > 0) begin
      checks++; if (acc_addr[0] !== 32'h0) begin errors++; $display("FAIL credit_addr got %h exp 0", acc_addr[0]); end
    end
    enable = 1'b0;
    resp_hold = 1'b0;
    wait_idle("credit");
    checks++; if (wr_cnt != 16) begin errors++; $display("FAIL credit_words got %0d exp 16", wr_cnt); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a[6] = '{32'h1000, 32'h1100, 32'h8000, 32'h8100, 32'h8000, 32'h8100};
    int n;
    do_reset();
    frame_base = 32'h1000;
    frame_words = 24'd32;
    enable = 1'b1;
    n = 0;
    while (acc_addr.size() < 1 && n < 100) begin step(1); n++; end
    frame_base = 32'h8000;
    n = 0;
    while (acc_addr.size() < 6 && n < 400) begin step(1); n++; end
    enable = 1'b0;
    wait_idle("wrap");
    checks++; if (acc_addr.size() != 6) begin errors++; $display("FAIL wrap_bursts got %0d exp 6", acc_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < acc_addr.size()) begin
        checks++;
        if (acc_addr[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, acc_addr[i], exp_a[i]); end
      end
    end
    checks++; if (fd_idx.size() != 3) begin errors++; $display("FAIL wrap_done_count got %0d exp 3", fd_idx.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < fd_idx.size()) begin
        checks++;
        if (fd_idx[i] != 32 * (i + 1)) begin errors++; $display("FAIL wrap_done_pos%0d got %0d exp %0d", i, fd_idx[i], 32 * (i + 1)); end
      end
    end
    checks++; if (stray_fd != 0) begin errors++; $display("FAIL wrap_stray_done got %0d exp 0", stray_fd); end
    if (wr_q.size() > 32) begin
      checks++; if (wr_q[16] !== pat(32'h1100)) begin errors++; $display("FAIL wrap_word16 got %h exp %h", wr_q[16], pat(32'h1100)); end
      checks++; if (wr_q[32] !== pat(32'h8000)) begin errors++; $display("FAIL wrap_word32 got %h exp %h", wr_q[32], pat(32'h8000)); end
    end
  endtask

  task automatic test_waitreq();
    int bad;
    do_reset();
    frame_base = 32'h2000;
    resp_hold = 1'b1;
    avm_waitrequest = 1'b1;
    enable = 1'b1;
    step(2);
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h2000) begin errors++; $display("FAIL wait_req read=%b addr=%h exp 1/2000", avm_read, avm_address); end
    bad = 0;
    repeat (5) begin
      step(1);
      if (avm_read !== 1'b1 || avm_address !== 32'h2000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wait_hold unstable_cycles=%0d exp 0", bad); end
    checks++; if (acc_addr.size() != 0) begin errors++; $display("FAIL wait_no_accept got %0d exp 0", acc_addr.size()); end
    avm_waitrequest = 1'b0;
    step(40);
    checks++; if (acc_addr.size() != 4) begin errors++; $display("FAIL wait_bursts got %0d exp 4", acc_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < acc_addr.size()) begin
        checks++;
        if (acc_addr[i] !== 32'h2000 + 32'(i * 256)) begin errors++; $display("FAIL wait_addr%0d got %h exp %h", i, acc_addr[i], 32'h2000 + 32'(i * 256)); end
      end
    end
    enable = 1'b0;
    resp_hold = 1'b0;
    wait_idle("wait");
    checks++; if (wr_cnt != 64) begin errors++; $display("FAIL wait_words got %0d exp 64", wr_cnt); end
  endtask

  task automatic test_drain();
    int n;
    do_reset();
    resp_hold = 1'b1;
    enable = 1'b1;
    n = 0;
    while (acc_addr.size() < 3 && n < 100) begin step(1); n++; end
    enable = 1'b0;
    step(10);
    checks++; if (acc_addr.size() != 3 || avm_read !== 1'b0) begin errors++; $display("FAIL drain_no_new bursts=%0d read=%b exp 3/0", acc_addr.size(), avm_read); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", busy); end
    resp_hold = 1'b0;
    n = 0;
    while (wr_cnt < 48 && n < 200) begin step(1); n++; end
    checks++; if (wr_cnt != 48) begin errors++; $display("FAIL drain_words got %0d exp 48", wr_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_last got %b exp 1", busy); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_fall got %b exp 0", busy); end
  endtask

  task automatic test_reset_midburst();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (wr_cnt < 5 && n < 100) begin step(1); n++; end
    rst_n = 1'b0;
    step(1);
    checks++; if (avm_read !== 1'b0 || avm_address !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_req read=%b addr=%h busy=%b exp 0/0/0", avm_read, avm_address, busy); end
    checks++; if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 128'h0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_wr en=%b data=%h done=%b exp 0/0/0", fifo_wr_en, fifo_wr_data, frame_done); end
    enable = 1'b0;
    rst_n = 1'b1;
    inj_valid = 1'b1;
    step(3);
    inj_valid = 1'b0;
    step(2);
    checks++; if (wr_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_late_data writes=%0d busy=%b exp 0/0", wr_cnt, busy); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_fill();
    test_credit();
    test_wrap();
    test_waitreq();
    test_drain();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Burst-read sequencer that fills the 128-bit pixel FIFO consumed by the VGA scan-out logic. Walks a frame buffer in DDR linearly, issuing fixed-length Avalon-MM burst reads whenever the FIFO has room, and writes returned data into the FIFO. Wraps to the frame base at frame end and picks up a new base only at frame boundaries, so buffer swaps never tear. Sits between the DDR controller's read port and the write side of the pixel FIFO.

## Interface
- ADDR_W, 32, byte address width
- BURST_LEN, 16, words (128-bit) per burst; power of two
- FIFO_DEPTH, 256, pixel FIFO depth in words
- MAX_OUTSTANDING, 4, maximum bursts in flight
- ddr_clk  in  1  clock
- ddr_reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; start/continue fetching
- frame_base  in  ADDR_W  byte address of frame start; 16-byte aligned, sampled only at frame boundaries
- frame_words  in  24  words per frame; nonzero multiple of BURST_LEN (640x480 = 76800)
- fifo_wr_used  in  $clog2(FIFO_DEPTH)+1  FIFO fill level
- avm_address  out  ADDR_W  burst start byte address
- avm_read  out  1  read request
- avm_burstcount  out  $clog2(BURST_LEN)+1  constant BURST_LEN
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data strobe
- avm_readdata  in  128  read data
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  128  FIFO write data
- frame_done  out  1  one-cycle pulse, last word of a frame written
- busy  out  1  high in RUN or DRAIN

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN when enable=1: latch frame_base into cur_base, req_addr=frame_base, req_cnt=0, rx_cnt=0.
- RUN -> DRAIN when enable=0. DRAIN -> IDLE when in_flight=0 and avm_read=0. In DRAIN, a request already asserted is held until accepted; no new requests.
- in_flight: words requested but not yet written to FIFO. +BURST_LEN on accept (avm_read & ~avm_waitrequest); -1 on fifo_wr_en; both same cycle -> net BURST_LEN-1.
- Issue (RUN, avm_read=0) when fifo_wr_used + in_flight + BURST_LEN <= FIFO_DEPTH and in_flight + BURST_LEN <= MAX_OUTSTANDING*BURST_LEN.
- On accept: req_cnt += BURST_LEN, req_addr += BURST_LEN*16. If req_cnt reaches frame_words: req_cnt=0, req_addr=frame_base (new base sampled here), cur_base updated.
- Data: fifo_wr_en/fifo_wr_data register avm_readdatavalid/avm_readdata (all states except IDLE). rx_cnt increments per write; at frame_words-1 -> 0 and frame_done pulses with that write.
- avm_burstcount always BURST_LEN. Address arithmetic wraps modulo 2^ADDR_W.
- Reset: avm_read 0, avm_address 0, avm_burstcount BURST_LEN, fifo_wr_en 0, fifo_wr_data 0, frame_done 0, busy 0, state IDLE, counters 0.

## Timing
- avm_read asserts the cycle after the issue condition is true; avm_address/avm_read stable while avm_waitrequest=1.
- Back-to-back bursts: one idle cycle minimum between accept and next avm_read.
- avm_readdatavalid -> fifo_wr_en latency: 1 cycle.
- frame_done coincident with fifo_wr_en of the frame's last word.
- fifo_wr_used is trusted as of current cycle; the credit term guarantees no overflow regardless of its one-cycle lag.
- frame_base change mid-frame: no effect until wrap. Re-enable from IDLE restarts at frame start.
- Reset mid-burst: all state cleared immediately; late readdatavalid after reset while IDLE is ignored.

## Test plan
- Reset, enable=1, fifo_wr_used=0, no waitrequest, 2-cycle read latency -> first avm_read at 0x0 with burstcount 16; 4 bursts issued (0x000,0x100,0x200,0x300) then stall at in_flight=64.
- fifo_wr_used=250 held -> no request (250+0+16>256); drop to 240 -> one request issued.
- frame_words=32, frame_base=0x1000 -> requests 0x1000,0x1100,0x1000,...; frame_done every 32 written words; base changed to 0x8000 mid-frame -> first 0x8000 request only after 0x1100.
- avm_waitrequest=1 for 5 cycles -> avm_address/avm_read held constant; accept counted exactly once.
- enable low with 3 bursts outstanding -> no new avm_read, all 48 words written, busy falls the cycle after in_flight reaches 0.
- ddr_reset_n asserted mid-burst -> all outputs at reset values next edge; following readdatavalid produces no fifo_wr_en.
